// File: rtl/instruction_fetch_if.sv
// Instruction fetch bus bundle.
// Groups the ROM port, the hazard/EX control inputs and the IF/ID outputs
// of the fetch stage so they travel as one port.
//   master : the fetch stage (drives IMEM_ADDR, PC, ID_*, HALTED, FETCH_FAULT)
//   slave  : the surrounding pipeline/ROM (drives IMEM_DATA, STALL, REDIRECT*)
interface instruction_fetch_if #(
    parameter int unsigned ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] IMEM_ADDR;
    logic [31:0]           IMEM_DATA;
    logic                  STALL;
    logic                  REDIRECT;
    logic [31:0]           REDIRECT_PC;
    logic [31:0]           PC;
    logic                  ID_VALID;
    logic [31:0]           ID_PC;
    logic [31:0]           ID_PC_PLUS4;
    logic [31:0]           ID_INSTR;
    logic                  HALTED;
    logic                  FETCH_FAULT;

    modport master (
        output IMEM_ADDR,
        input  IMEM_DATA,
        input  STALL,
        input  REDIRECT,
        input  REDIRECT_PC,
        output PC,
        output ID_VALID,
        output ID_PC,
        output ID_PC_PLUS4,
        output ID_INSTR,
        output HALTED,
        output FETCH_FAULT
    );

    modport slave (
        input  IMEM_ADDR,
        output IMEM_DATA,
        output STALL,
        output REDIRECT,
        output REDIRECT_PC,
        input  PC,
        input  ID_VALID,
        input  ID_PC,
        input  ID_PC_PLUS4,
        input  ID_INSTR,
        input  HALTED,
        input  FETCH_FAULT
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage of the pipelined RV32I core.
// Holds the PC, addresses the asynchronous-read instruction ROM and captures
// the returned word into the IF/ID register. Handles hazard stall, EX
// redirect and a sticky RUN/HALT/FAULT state machine.
// Ports:
//   CLK   : clock, all state updates on the rising edge
//   RST   : synchronous active-high reset
//   bus   : instruction_fetch_if.master
//           IMEM_ADDR   = PC[ADDR_WIDTH+1:2] (combinational)
//           IMEM_DATA   ROM word for IMEM_ADDR, same cycle
//           STALL       hold PC and IF/ID
//           REDIRECT/REDIRECT_PC  taken branch/jump target
//           PC, ID_VALID, ID_PC, ID_PC_PLUS4, ID_INSTR  fetch/IF-ID state
//           HALTED, FETCH_FAULT   sticky terminal states
module instruction_fetch #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter logic [31:0] RESET_PC   = 32'h00000000
) (
    input logic                CLK,
    input logic                RST,
    instruction_fetch_if.master bus
);

    localparam logic [31:0] NOP = 32'h00000013;
    localparam int unsigned HI_LSB = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        RUN,
        HALT,
        FAULT
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;
    logic        halted;
    logic        fetch_fault;

    logic [31:0] pc_plus4;
    logic        pc_in_range;
    logic        redirect_aligned;

    // Carry out of the add is dropped; the range check faults before any
    // wrapped address could ever be fetched.
    assign pc_plus4         = pc + 32'd4;
    assign pc_in_range      = (pc >> HI_LSB) == '0;
    assign redirect_aligned = bus.REDIRECT_PC[1:0] == 2'b00;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= RUN;
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
            id_instr    <= NOP;
            halted      <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.REDIRECT) begin
                        // Wrong-path word in IF/ID is flushed either way.
                        id_valid <= 1'b0;
                        id_instr <= NOP;
                        if (redirect_aligned) begin
                            pc <= bus.REDIRECT_PC;
                        end else begin
                            state       <= FAULT;
                            fetch_fault <= 1'b1;
                        end
                    end else if (bus.STALL) begin
                        // Hold PC and IF/ID.
                    end else if (!pc_in_range) begin
                        state       <= FAULT;
                        fetch_fault <= 1'b1;
                        id_valid    <= 1'b0;
                        id_instr    <= NOP;
                    end else if (bus.IMEM_DATA == '0) begin
                        state    <= HALT;
                        halted   <= 1'b1;
                        id_valid <= 1'b0;
                        id_instr <= NOP;
                    end else begin
                        id_valid    <= 1'b1;
                        id_pc       <= pc;
                        id_pc_plus4 <= pc_plus4;
                        id_instr    <= bus.IMEM_DATA;
                        pc          <= pc_plus4;
                    end
                end
                HALT, FAULT: begin
                    // Sticky; PC and IF/ID frozen until reset.
                    id_valid <= 1'b0;
                    id_instr <= NOP;
                end
                default: begin
                    state       <= FAULT;
                    fetch_fault <= 1'b1;
                    halted      <= 1'b0;
                    id_valid    <= 1'b0;
                    id_instr    <= NOP;
                end
            endcase
        end
    end

    assign bus.IMEM_ADDR   = pc[ADDR_WIDTH+1:2];
    assign bus.PC          = pc;
    assign bus.ID_VALID    = id_valid;
    assign bus.ID_PC       = id_pc;
    assign bus.ID_PC_PLUS4 = id_pc_plus4;
    assign bus.ID_INSTR    = id_instr;
    assign bus.HALTED      = halted;
    assign bus.FETCH_FAULT = fetch_fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch.
// Instance A: ADDR_WIDTH=12, directed stall/redirect/halt/fault/reset sequence.
// Instance B: ADDR_WIDTH=2, free-running sequential fetch into the range end.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h00000013;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic        stall_a = 1'b0;
    logic        redirect_a = 1'b0;
    logic [31:0] redirect_pc_a = '0;

    logic [31:0] rom_a [0:4095];
    logic [31:0] rom_b [0:3];

    instruction_fetch_if #(.ADDR_WIDTH(12)) bus_a ();
    instruction_fetch_if #(.ADDR_WIDTH(2))  bus_b ();

    assign bus_a.IMEM_DATA   = rom_a[bus_a.IMEM_ADDR];
    assign bus_a.STALL       = stall_a;
    assign bus_a.REDIRECT    = redirect_a;
    assign bus_a.REDIRECT_PC = redirect_pc_a;

    assign bus_b.IMEM_DATA   = rom_b[bus_b.IMEM_ADDR];
    assign bus_b.STALL       = 1'b0;
    assign bus_b.REDIRECT    = 1'b0;
    assign bus_b.REDIRECT_PC = '0;

    instruction_fetch #(.ADDR_WIDTH(12), .RESET_PC(32'h00000000)) dut_a (
        .CLK(CLK), .RST(RST), .bus(bus_a)
    );
    instruction_fetch #(.ADDR_WIDTH(2), .RESET_PC(32'h00000000)) dut_b (
        .CLK(CLK), .RST(RST), .bus(bus_b)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 running, 1 halted, 2 faulted
    bit          m_init = 1'b0;
    logic [31:0] m_pc    [2];
    int          m_mode  [2];
    bit          m_valid [2];
    logic [31:0] m_idpc  [2];
    logic [31:0] m_plus4 [2];
    logic [31:0] m_instr [2];

    task automatic model_edge(input int k, input int aw, input bit st, input bit rd,
                              input logic [31:0] rpc);
        logic [31:0] word;
        longint unsigned limit;
        limit = 64'd4 << aw;
        word  = (k == 0) ? rom_a[m_pc[k][13:2]] : rom_b[m_pc[k][3:2]];
        if (RST) begin
            m_pc[k] = 32'h0; m_mode[k] = 0; m_valid[k] = 0;
            m_idpc[k] = 0; m_plus4[k] = 0; m_instr[k] = NOP;
        end else if (m_mode[k] != 0) begin
            m_valid[k] = 0;
        end else if (rd) begin
            m_valid[k] = 0;
            if (rpc % 4 == 0) m_pc[k] = rpc;
            else m_mode[k] = 2;
        end else if (st) begin
            // nothing moves
        end else if (longint'(m_pc[k]) >= limit) begin
            m_mode[k] = 2; m_valid[k] = 0;
        end else if (word == 32'h0) begin
            m_mode[k] = 1; m_valid[k] = 0;
        end else begin
            m_valid[k] = 1; m_idpc[k] = m_pc[k];
            m_plus4[k] = m_pc[k] + 4; m_instr[k] = word; m_pc[k] = m_pc[k] + 4;
        end
        if (!m_valid[k]) m_instr[k] = NOP;
    endtask

    always @(posedge CLK) begin
        if (RST) m_init = 1'b1;
        if (m_init) begin
            model_edge(0, 12, stall_a, redirect_a, redirect_pc_a);
            model_edge(1, 2, 1'b0, 1'b0, 32'h0);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        if (m_init) begin
            chk("A.PC", bus_a.PC, m_pc[0]);
            chk("A.IMEM_ADDR", 32'(bus_a.IMEM_ADDR), (m_pc[0] >> 2) & 32'hFFF);
            chk("A.ID_VALID", 32'(bus_a.ID_VALID), 32'(m_valid[0]));
            chk("A.ID_PC", bus_a.ID_PC, m_idpc[0]);
            chk("A.ID_PC_PLUS4", bus_a.ID_PC_PLUS4, m_plus4[0]);
            chk("A.ID_INSTR", bus_a.ID_INSTR, m_instr[0]);
            chk("A.HALTED", 32'(bus_a.HALTED), 32'(m_mode[0] == 1));
            chk("A.FETCH_FAULT", 32'(bus_a.FETCH_FAULT), 32'(m_mode[0] == 2));
            chk("B.PC", bus_b.PC, m_pc[1]);
            chk("B.IMEM_ADDR", 32'(bus_b.IMEM_ADDR), (m_pc[1] >> 2) & 32'h3);
            chk("B.ID_VALID", 32'(bus_b.ID_VALID), 32'(m_valid[1]));
            chk("B.ID_PC", bus_b.ID_PC, m_idpc[1]);
            chk("B.ID_PC_PLUS4", bus_b.ID_PC_PLUS4, m_plus4[1]);
            chk("B.ID_INSTR", bus_b.ID_INSTR, m_instr[1]);
            chk("B.HALTED", 32'(bus_b.HALTED), 32'(m_mode[1] == 1));
            chk("B.FETCH_FAULT", 32'(bus_b.FETCH_FAULT), 32'(m_mode[1] == 2));
        end
    end

    // ---------------- directed stimulus with literal pins ----------------
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom_a[i] = 32'h0;
        rom_a[0] = 32'h00150513;
        rom_a[1] = 32'h00253593;
        rom_a[2] = 32'h00053593;
        rom_a[3] = 32'h00000000;
        rom_a[7] = 32'h00700393;
        rom_a[8] = 32'h00800413;
        rom_b[0] = 32'h00100093;
        rom_b[1] = 32'h00200113;
        rom_b[2] = 32'h00300193;
        rom_b[3] = 32'h00400213;

        // Reset state
        step(); step();
        chk("rst PC", bus_a.PC, 32'h0);
        chk("rst ID_VALID", 32'(bus_a.ID_VALID), 32'h0);
        chk("rst ID_INSTR", bus_a.ID_INSTR, NOP);
        chk("rst HALTED", 32'(bus_a.HALTED), 32'h0);
        RST = 1'b0;

        // Sequential fetch into a zero word
        step();
        chk("run0 ID_PC", bus_a.ID_PC, 32'h0);
        chk("run0 ID_INSTR", bus_a.ID_INSTR, 32'h00150513);
        chk("run0 ID_PC_PLUS4", bus_a.ID_PC_PLUS4, 32'h4);
        step();
        chk("run1 ID_PC", bus_a.ID_PC, 32'h4);
        chk("run1 ID_INSTR", bus_a.ID_INSTR, 32'h00253593);
        step();
        chk("run2 ID_PC", bus_a.ID_PC, 32'h8);
        chk("run2 ID_PC_PLUS4", bus_a.ID_PC_PLUS4, 32'hC);
        step();
        chk("halt HALTED", 32'(bus_a.HALTED), 32'h1);
        chk("halt ID_VALID", 32'(bus_a.ID_VALID), 32'h0);
        chk("halt PC", bus_a.PC, 32'hC);
        chk("B end PC", bus_b.PC, 32'h10);
        chk("B end ID_PC", bus_b.ID_PC, 32'hC);
        chk("B end FAULT", 32'(bus_b.FETCH_FAULT), 32'h0);
        step();
        chk("halt frozen PC", bus_a.PC, 32'hC);
        chk("B range FAULT", 32'(bus_b.FETCH_FAULT), 32'h1);
        chk("B range PC", bus_b.PC, 32'h10);

        // Reset out of HALT
        RST = 1'b1;
        step();
        chk("rst2 PC", bus_a.PC, 32'h0);
        chk("rst2 HALTED", 32'(bus_a.HALTED), 32'h0);
        chk("rst2 ID_VALID", 32'(bus_a.ID_VALID), 32'h0);
        RST = 1'b0;
        step();
        chk("rst2 fetch ID_PC", bus_a.ID_PC, 32'h0);
        chk("rst2 fetch ID_INSTR", bus_a.ID_INSTR, 32'h00150513);
        step();

        // Stall for three edges at PC=8
        stall_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall PC", bus_a.PC, 32'h8);
            chk("stall ID_INSTR", bus_a.ID_INSTR, 32'h00253593);
        end
        stall_a = 1'b0;
        step();
        chk("resume ID_PC", bus_a.ID_PC, 32'h8);

        // PC=12 points at a zero word: stall and redirect must not halt
        stall_a = 1'b1;
        step();
        chk("stall zero HALTED", 32'(bus_a.HALTED), 32'h0);
        redirect_a = 1'b1;
        redirect_pc_a = 32'h0000001C;
        step();
        chk("redir PC", bus_a.PC, 32'h1C);
        chk("redir ID_VALID", 32'(bus_a.ID_VALID), 32'h0);
        chk("redir HALTED", 32'(bus_a.HALTED), 32'h0);
        redirect_a = 1'b0;
        stall_a = 1'b0;
        step();
        chk("redir fetch ID_PC", bus_a.ID_PC, 32'h1C);
        chk("redir fetch ID_INSTR", bus_a.ID_INSTR, 32'h00700393);

        // Misaligned redirect faults; later pulses ignored
        redirect_a = 1'b1;
        redirect_pc_a = 32'h00000022;
        step();
        chk("misalign FAULT", 32'(bus_a.FETCH_FAULT), 32'h1);
        chk("misalign PC", bus_a.PC, 32'h20);
        chk("misalign ID_VALID", 32'(bus_a.ID_VALID), 32'h0);
        redirect_pc_a = 32'h00000040;
        stall_a = 1'b1;
        step();
        chk("fault sticky PC", bus_a.PC, 32'h20);
        chk("fault sticky FAULT", 32'(bus_a.FETCH_FAULT), 32'h1);
        redirect_a = 1'b0;
        stall_a = 1'b0;
        step();
        chk("fault frozen PC", bus_a.PC, 32'h20);
        chk("fault ID_INSTR", bus_a.ID_INSTR, NOP);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
